// File: rtl/face_window_scheduler.sv
`timescale 1ns/1ps
// face_window_scheduler
//   Sequences the LBP/SVM face verifier over candidate windows taken from a
//   frame buffer. For each candidate (x,y) it holds the verifier in reset,
//   streams WIN_ROW x WIN_COL pixels from the frame buffer, waits for the
//   verifier's done pulse (or a timeout), samples the class bit and returns
//   a result tagged with the candidate coordinates.
//
//   Optional feature macro: FACE_SCHED_STATS_EN (saturating window/face counters).
//
// Ports
//   clock, reset_n                  clock, asynchronous active-low reset
//   cand_valid/cand_ready/x/y       candidate input handshake
//   fb_addr, fb_rd_en               frame-buffer read port (1-cycle latency)
//   ver_reset, ver_enable,
//   ver_address                     verifier control, aligned with fb data
//   ver_done, ver_class             verifier completion pulse and class bit
//   res_valid/res_ready/x/y/face/err result output handshake
//   busy                            scheduler not idle
//   stat_windows, stat_faces        result statistics (0 when stats disabled)
module face_window_scheduler #(
  parameter int unsigned IM_COL     = 320,
  parameter int unsigned IM_ROW     = 240,
  parameter int unsigned WIN_COL    = 26,
  parameter int unsigned WIN_ROW    = 26,
  parameter int unsigned ADDR_BITS  = 17,
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 8191
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 cand_valid,
  output logic                 cand_ready,
  input  logic [8:0]           cand_x,
  input  logic [7:0]           cand_y,
  output logic [ADDR_BITS-1:0] fb_addr,
  output logic                 fb_rd_en,
  output logic                 ver_reset,
  output logic                 ver_enable,
  output logic [9:0]           ver_address,
  input  logic                 ver_done,
  input  logic                 ver_class,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [8:0]           res_x,
  output logic [7:0]           res_y,
  output logic                 res_face,
  output logic [1:0]           res_err,
  output logic                 busy,
  output logic [15:0]          stat_windows,
  output logic [15:0]          stat_faces
);

  localparam int unsigned WIN_PIX  = WIN_COL * WIN_ROW;
  localparam int unsigned MAX_A    = (TIMEOUT > WIN_PIX) ? TIMEOUT : WIN_PIX;
  localparam int unsigned MAX_CNT  = (MAX_A > RST_CYCLES) ? MAX_A : RST_CYCLES;
  localparam int unsigned CNT_W    = $clog2(MAX_CNT + 1);
  localparam int unsigned COL_W    = $clog2(WIN_COL + 1);
  localparam int unsigned ROW_STEP = IM_COL - WIN_COL + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_STREAM, S_WAIT, S_SETTLE, S_RESULT
  } state_t;

  state_t                 r_state, w_state;
  logic [CNT_W-1:0]       r_cnt, w_cnt;
  logic [COL_W-1:0]       r_col, w_col;
  logic [ADDR_BITS-1:0]   r_base, w_base;
  logic [8:0]             r_x, w_x;
  logic [7:0]             r_y, w_y;
  logic                   r_cand_ready, w_cand_ready;
  logic [ADDR_BITS-1:0]   r_fb_addr, w_fb_addr;
  logic                   r_fb_rd_en, w_fb_rd_en;
  logic                   r_ver_reset, w_ver_reset;
  logic                   r_ver_enable, w_ver_enable;
  logic [9:0]             r_ver_address, w_ver_address;
  logic                   r_res_valid, w_res_valid;
  logic                   r_res_face, w_res_face;
  logic [1:0]             r_res_err, w_res_err;
  logic                   r_busy, w_busy;
  logic                   w_oob;
  logic                   w_res_hs;

  // Window must fit entirely inside the frame
  assign w_oob = ((32'(cand_x) + WIN_COL) > IM_COL) || ((32'(cand_y) + WIN_ROW) > IM_ROW);
  assign w_res_hs = (r_state == S_RESULT) && res_ready;

  // State and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_col         <= '0;
      r_base        <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_cand_ready  <= 1'b0;
      r_fb_addr     <= '0;
      r_fb_rd_en    <= 1'b0;
      r_ver_reset   <= 1'b1;
      r_ver_enable  <= 1'b0;
      r_ver_address <= '0;
      r_res_valid   <= 1'b0;
      r_res_face    <= 1'b0;
      r_res_err     <= 2'b00;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_cnt         <= w_cnt;
      r_col         <= w_col;
      r_base        <= w_base;
      r_x           <= w_x;
      r_y           <= w_y;
      r_cand_ready  <= w_cand_ready;
      r_fb_addr     <= w_fb_addr;
      r_fb_rd_en    <= w_fb_rd_en;
      r_ver_reset   <= w_ver_reset;
      r_ver_enable  <= w_ver_enable;
      r_ver_address <= w_ver_address;
      r_res_valid   <= w_res_valid;
      r_res_face    <= w_res_face;
      r_res_err     <= w_res_err;
      r_busy        <= w_busy;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state       = r_state;
    w_cnt         = r_cnt;
    w_col         = r_col;
    w_base        = r_base;
    w_x           = r_x;
    w_y           = r_y;
    w_fb_addr     = r_fb_addr;
    w_fb_rd_en    = 1'b0;
    w_ver_reset   = r_ver_reset;
    w_ver_enable  = 1'b0;
    w_ver_address = r_ver_address;
    w_res_valid   = r_res_valid;
    w_res_face    = r_res_face;
    w_res_err     = r_res_err;

    case (r_state)
      S_IDLE: begin
        w_ver_reset = 1'b1;
        if (cand_valid && r_cand_ready) begin
          w_x    = cand_x;
          w_y    = cand_y;
          w_base = ADDR_BITS'(32'(cand_y) * IM_COL + 32'(cand_x));
          w_cnt  = '0;
          w_res_face = 1'b0;
          if (w_oob) begin
            w_state     = S_RESULT;
            w_res_valid = 1'b1;
            w_res_err   = 2'b10;
          end else begin
            w_state   = S_CLEAR;
            w_res_err = 2'b00;
          end
        end
      end

      S_CLEAR: begin
        w_ver_reset = 1'b1;
        if (r_cnt == CNT_W'(RST_CYCLES - 1)) begin
          w_state     = S_STREAM;
          w_cnt       = '0;
          w_col       = '0;
          w_fb_addr   = r_base;
          w_fb_rd_en  = 1'b1;
          w_ver_reset = 1'b0;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end

      // r_cnt is the index of the pixel being read this cycle; the verifier
      // sees it one cycle later together with the BRAM data.
      S_STREAM: begin
        w_ver_reset   = 1'b0;
        w_ver_enable  = 1'b1;
        w_ver_address = 10'(r_cnt);
        if (r_cnt == CNT_W'(WIN_PIX - 1)) begin
          w_state = S_WAIT;
          w_cnt   = '0;
        end else begin
          w_fb_rd_en = 1'b1;
          w_cnt      = r_cnt + CNT_W'(1);
          if (r_col == COL_W'(WIN_COL - 1)) begin
            w_col     = '0;
            w_fb_addr = r_fb_addr + ADDR_BITS'(ROW_STEP);
          end else begin
            w_col     = r_col + COL_W'(1);
            w_fb_addr = r_fb_addr + ADDR_BITS'(1);
          end
        end
      end

      // ver_done takes priority over a coincident timeout
      S_WAIT: begin
        w_ver_address = 10'(WIN_PIX - 1);
        if (ver_done) begin
          w_state = S_SETTLE;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_state     = S_RESULT;
          w_res_valid = 1'b1;
          w_res_face  = 1'b0;
          w_res_err   = 2'b01;
          w_ver_reset = 1'b1;
        end else begin
          w_ver_enable = 1'b1;
          w_cnt        = r_cnt + CNT_W'(1);
        end
      end

      // Class register is valid the cycle after ver_done
      S_SETTLE: begin
        w_state     = S_RESULT;
        w_res_valid = 1'b1;
        w_res_face  = ver_class;
        w_res_err   = 2'b00;
        w_ver_reset = 1'b1;
      end

      S_RESULT: begin
        w_ver_reset = 1'b1;
        if (res_ready) begin
          w_state     = S_IDLE;
          w_res_valid = 1'b0;
        end
      end

      default: w_state = S_IDLE;
    endcase

    w_cand_ready = (w_state == S_IDLE);
    w_busy       = (w_state != S_IDLE);
  end

  assign cand_ready  = r_cand_ready;
  assign fb_addr     = r_fb_addr;
  assign fb_rd_en    = r_fb_rd_en;
  assign ver_reset   = r_ver_reset;
  assign ver_enable  = r_ver_enable;
  assign ver_address = r_ver_address;
  assign res_valid   = r_res_valid;
  assign res_x       = r_x;
  assign res_y       = r_y;
  assign res_face    = r_res_face;
  assign res_err     = r_res_err;
  assign busy        = r_busy;

`ifdef FACE_SCHED_STATS_EN
  logic [15:0] r_stat_windows;
  logic [15:0] r_stat_faces;

  // Saturating counters, updated on each result handshake
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_windows <= '0;
      r_stat_faces   <= '0;
    end else if (w_res_hs) begin
      if (r_stat_windows != 16'hFFFF) r_stat_windows <= r_stat_windows + 16'd1;
      if (r_res_face && (r_stat_faces != 16'hFFFF)) r_stat_faces <= r_stat_faces + 16'd1;
    end
  end

  assign stat_windows = r_stat_windows;
  assign stat_faces   = r_stat_faces;
`else
  assign stat_windows = 16'd0;
  assign stat_faces   = 16'd0;
`endif

endmodule

// File: tb/tb_face_window_scheduler.sv
`timescale 1ns/1ps
// tb_face_window_scheduler
//   Scenario tasks drive candidates and verifier responses; expected results
//   are pushed to a scoreboard queue at accept and popped at each result.
module tb_face_window_scheduler;

  localparam int unsigned IM_COL     = 320;
  localparam int unsigned IM_ROW     = 240;
  localparam int unsigned WIN_COL    = 26;
  localparam int unsigned WIN_ROW    = 26;
  localparam int unsigned ADDR_BITS  = 17;
  localparam int unsigned RST_CYCLES = 4;
  localparam int unsigned TIMEOUT    = 8191;
  localparam int unsigned WIN_PIX    = WIN_COL * WIN_ROW;
  // Cycle (accept = 0) of the first WAIT cycle
  localparam int          WAIT_AT    = int'(RST_CYCLES + WIN_PIX + 1);

  logic                 clock, reset_n;
  logic                 cand_valid, cand_ready;
  logic [8:0]           cand_x;
  logic [7:0]           cand_y;
  logic [ADDR_BITS-1:0] fb_addr;
  logic                 fb_rd_en, ver_reset, ver_enable;
  logic [9:0]           ver_address;
  logic                 ver_done, ver_class;
  logic                 res_valid, res_ready;
  logic [8:0]           res_x;
  logic [7:0]           res_y;
  logic                 res_face;
  logic [1:0]           res_err;
  logic                 busy;
  logic [15:0]          stat_windows, stat_faces;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic       face;
    logic [1:0] err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  face_window_scheduler #(
    .IM_COL(IM_COL), .IM_ROW(IM_ROW), .WIN_COL(WIN_COL), .WIN_ROW(WIN_ROW),
    .ADDR_BITS(ADDR_BITS), .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .cand_valid(cand_valid), .cand_ready(cand_ready), .cand_x(cand_x), .cand_y(cand_y),
    .fb_addr(fb_addr), .fb_rd_en(fb_rd_en),
    .ver_reset(ver_reset), .ver_enable(ver_enable), .ver_address(ver_address),
    .ver_done(ver_done), .ver_class(ver_class),
    .res_valid(res_valid), .res_ready(res_ready), .res_x(res_x), .res_y(res_y),
    .res_face(res_face), .res_err(res_err), .busy(busy),
    .stat_windows(stat_windows), .stat_faces(stat_faces)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  // Offers a candidate; returns at the negedge of cycle 1 (accept = cycle 0)
  task automatic accept(input logic [8:0] x, input logic [7:0] y);
    int t = 0;
    while (cand_ready !== 1'b1 && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (cand_ready !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL accept_ready: cand_ready=%b required 1", cand_ready);
    end
    cand_valid = 1'b1; cand_x = x; cand_y = y;
    @(negedge clock);
    cand_valid = 1'b0;
  endtask

  task automatic wait_res(input int limit, output int cyc);
    cyc = 0;
    while (res_valid !== 1'b1 && cyc < limit) begin
      @(negedge clock);
      cyc++;
    end
    if (res_valid !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL wait_res: res_valid=%b required 1 after %0d cycles", res_valid, cyc);
    end
  endtask

  // Full in-bounds window; ver_done 'dly' cycles after WAIT entry.
  // Returns at the negedge of the first RESULT cycle.
  task automatic run_core(input logic [8:0] x, input logic [7:0] y, input logic cls, input int dly);
    accept(x, y);
    sb.push_back('{x: x, y: y, face: cls, err: 2'b00});
    repeat (WAIT_AT + dly - 1) @(negedge clock);
    ver_done = 1'b1;
    @(negedge clock);
    ver_done = 1'b0; ver_class = cls;
    @(negedge clock);
    ver_class = 1'b0;
  endtask

  task automatic take_result();
    res_ready = 1'b1;
    @(negedge clock);
    res_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clock);
    n_tests++;
    if ({cand_ready, ver_reset, fb_rd_en, ver_enable, res_valid, busy, res_face, res_err} !== 9'b010000000
        || fb_addr !== '0 || ver_address !== 10'd0 || stat_windows !== 16'd0 || stat_faces !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_values: rdy=%b vrst=%b rd=%b ven=%b rv=%b busy=%b addr=%0d vaddr=%0d required rdy=0 vrst=1 rest 0",
               cand_ready, ver_reset, fb_rd_en, ver_enable, res_valid, busy, fb_addr, ver_address);
    end
    reset_n = 1'b1;
    @(negedge clock);
    n_tests++;
    if (cand_ready !== 1'b1 || busy !== 1'b0 || ver_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset: cand_ready=%b busy=%b ver_reset=%b required 1 0 1", cand_ready, busy, ver_reset);
    end
  endtask

  task automatic test_face();
    int bad_rd = 0, bad_addr = 0, bad_ven = 0, bad_vrst = 0;
    int pix, va;
    logic exp_rd, exp_ven, exp_vrst;
    logic [ADDR_BITS-1:0] exp_addr;
    logic [ADDR_BITS-1:0] base;
    exp_t e;
    base = ADDR_BITS'(20 * IM_COL + 10);
    accept(9'd10, 8'd20);
    sb.push_back('{x: 9'd10, y: 8'd20, face: 1'b1, err: 2'b00});
    for (int cyc = 1; cyc <= WAIT_AT + 50; cyc++) begin
      exp_rd   = (cyc >= int'(RST_CYCLES) + 1) && (cyc <= int'(RST_CYCLES + WIN_PIX));
      exp_ven  = (cyc >= int'(RST_CYCLES) + 2);
      exp_vrst = (cyc <= int'(RST_CYCLES));
      pix      = cyc - int'(RST_CYCLES) - 1;
      exp_addr = base + ADDR_BITS'((pix / int'(WIN_COL)) * int'(IM_COL) + (pix % int'(WIN_COL)));
      va       = cyc - int'(RST_CYCLES) - 2;
      if (va > int'(WIN_PIX) - 1) va = int'(WIN_PIX) - 1;
      if (fb_rd_en !== exp_rd) bad_rd++;
      if (exp_rd && fb_addr !== exp_addr) begin
        if (bad_addr == 0) $display("FAIL stream_addr: cycle %0d fb_addr=%0d required %0d", cyc, fb_addr, exp_addr);
        bad_addr++;
      end
      if (ver_enable !== exp_ven || (exp_ven && ver_address !== 10'(va))) bad_ven++;
      if (ver_reset !== exp_vrst) bad_vrst++;
      // Spurious done pulses during STREAM must be ignored
      ver_done = (cyc == 100) || (cyc == WAIT_AT + 50);
      if (cyc < WAIT_AT + 50) @(negedge clock);
    end
    @(negedge clock);
    ver_done = 1'b0; ver_class = 1'b1;
    @(negedge clock);
    ver_class = 1'b0;
    n_tests++; if (bad_rd != 0)   begin n_fail++; $display("FAIL stream_rd_en: %0d bad cycles, required 0", bad_rd); end
    n_tests++; if (bad_addr != 0) begin n_fail++; $display("FAIL stream_addr_total: %0d bad cycles, required 0", bad_addr); end
    n_tests++; if (bad_ven != 0)  begin n_fail++; $display("FAIL ver_enable_address: %0d bad cycles, required 0", bad_ven); end
    n_tests++; if (bad_vrst != 0) begin n_fail++; $display("FAIL ver_reset_pulse: %0d bad cycles, required 0", bad_vrst); end
    n_tests++;
    if (res_valid !== 1'b1) begin n_fail++; $display("FAIL face_latency: res_valid=%b required 1 at WAIT+52", res_valid); end
    e = sb.pop_front();
    n_tests++;
    if ({res_x, res_y, res_face, res_err} !== e) begin
      n_fail++;
      $display("FAIL face_result: got x=%0d y=%0d face=%b err=%b required x=%0d y=%0d face=%b err=%b",
               res_x, res_y, res_face, res_err, e.x, e.y, e.face, e.err);
    end
    take_result();
  endtask

  task automatic test_oob();
    logic [8:0] xs[3] = '{9'd300, 9'd0,   9'd511};
    logic [7:0] ys[3] = '{8'd0,   8'd215, 8'd255};
    int cyc;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      accept(xs[i], ys[i]);
      sb.push_back('{x: xs[i], y: ys[i], face: 1'b0, err: 2'b10});
      n_tests++;
      if (fb_rd_en !== 1'b0 || ver_reset !== 1'b1 || ver_enable !== 1'b0) begin
        n_fail++;
        $display("FAIL oob_no_activity[%0d]: rd=%b vrst=%b ven=%b required 0 1 0", i, fb_rd_en, ver_reset, ver_enable);
      end
      wait_res(1, cyc);
      e = sb.pop_front();
      n_tests++;
      if ({res_x, res_y, res_face, res_err} !== e) begin
        n_fail++;
        $display("FAIL oob_result[%0d]: got x=%0d y=%0d face=%b err=%b required x=%0d y=%0d face=%b err=%b",
                 i, res_x, res_y, res_face, res_err, e.x, e.y, e.face, e.err);
      end
      take_result();
    end
  endtask

  task automatic test_timeout();
    int cyc;
    exp_t e;
    accept(9'd0, 8'd0);
    sb.push_back('{x: 9'd0, y: 8'd0, face: 1'b0, err: 2'b01});
    wait_res(WAIT_AT + int'(TIMEOUT) + 20, cyc);
    n_tests++;
    if (cyc + 1 != WAIT_AT + int'(TIMEOUT)) begin
      n_fail++;
      $display("FAIL timeout_cycle: result at cycle %0d required %0d", cyc + 1, WAIT_AT + int'(TIMEOUT));
    end
    e = sb.pop_front();
    n_tests++;
    if ({res_x, res_y, res_face, res_err} !== e) begin
      n_fail++;
      $display("FAIL timeout_result: got face=%b err=%b required face=%b err=%b", res_face, res_err, e.face, e.err);
    end
    take_result();
  endtask

  task automatic test_done_at_timeout();
    exp_t e;
    run_core(9'd2, 8'd3, 1'b1, int'(TIMEOUT) - 1);
    n_tests++;
    if (res_valid !== 1'b1) begin n_fail++; $display("FAIL done_vs_timeout_valid: res_valid=%b required 1", res_valid); end
    e = sb.pop_front();
    n_tests++;
    if ({res_x, res_y, res_face, res_err} !== e) begin
      n_fail++;
      $display("FAIL done_vs_timeout: got face=%b err=%b required face=%b err=%b", res_face, res_err, e.face, e.err);
    end
    take_result();
  endtask

  task automatic test_back_to_back();
    int bad = 0, cyc;
    exp_t e;
    run_core(9'd0, 8'd214, 1'b0, 0);
    cand_valid = 1'b1; cand_x = 9'd295; cand_y = 8'd0;
    for (int i = 0; i < 20; i++) begin
      if (res_valid !== 1'b1 || cand_ready !== 1'b0 || busy !== 1'b1 ||
          {res_x, res_y, res_face, res_err} !== sb[0]) bad++;
      @(negedge clock);
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL backpressure_hold: %0d bad cycles, required 0", bad); end
    e = sb.pop_front();
    n_tests++;
    if ({res_x, res_y, res_face, res_err} !== e) begin
      n_fail++;
      $display("FAIL backpressure_result: got x=%0d y=%0d face=%b err=%b required x=%0d y=%0d face=%b err=%b",
               res_x, res_y, res_face, res_err, e.x, e.y, e.face, e.err);
    end
    // Pending candidate is taken in the IDLE cycle after the handshake
    take_result();
    sb.push_back('{x: 9'd295, y: 8'd0, face: 1'b0, err: 2'b10});
    @(negedge clock);
    cand_valid = 1'b0;
    wait_res(1, cyc);
    e = sb.pop_front();
    n_tests++;
    if ({res_x, res_y, res_face, res_err} !== e) begin
      n_fail++;
      $display("FAIL next_after_handshake: got x=%0d y=%0d err=%b required x=%0d y=%0d err=%b",
               res_x, res_y, res_err, e.x, e.y, e.err);
    end
    take_result();
  endtask

  task automatic test_reset_midstream();
    exp_t e;
    accept(9'd5, 8'd5);
    repeat (RST_CYCLES + 10) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({cand_ready, ver_reset, fb_rd_en, ver_enable, res_valid, busy} !== 6'b010000 || fb_addr !== '0) begin
      n_fail++;
      $display("FAIL async_reset: rdy=%b vrst=%b rd=%b ven=%b rv=%b busy=%b addr=%0d required 0 1 0 0 0 0 0",
               cand_ready, ver_reset, fb_rd_en, ver_enable, res_valid, busy, fb_addr);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    run_core(9'd40, 8'd30, 1'b1, 3);
    e = sb.pop_front();
    n_tests++;
    if ({res_x, res_y, res_face, res_err} !== e) begin
      n_fail++;
      $display("FAIL after_reset_result: got x=%0d y=%0d face=%b err=%b required x=%0d y=%0d face=%b err=%b",
               res_x, res_y, res_face, res_err, e.x, e.y, e.face, e.err);
    end
    take_result();
  endtask

  task automatic test_stats();
    logic cls[3] = '{1'b1, 1'b0, 1'b1};
    int exp_w, exp_f;
    exp_t e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      run_core(9'(20 * i), 8'(10 * i), cls[i], i);
      e = sb.pop_front();
      n_tests++;
      if ({res_x, res_y, res_face, res_err} !== e) begin
        n_fail++;
        $display("FAIL stats_result[%0d]: got face=%b err=%b required face=%b err=%b", i, res_face, res_err, e.face, e.err);
      end
      take_result();
    end
`ifdef FACE_SCHED_STATS_EN
    exp_w = 3; exp_f = 2;
`else
    exp_w = 0; exp_f = 0;
`endif
    n_tests++;
    if (stat_windows !== 16'(exp_w) || stat_faces !== 16'(exp_f)) begin
      n_fail++;
      $display("FAIL stats: windows=%0d faces=%0d required %0d %0d", stat_windows, stat_faces, exp_w, exp_f);
    end
  endtask

  initial begin
    reset_n = 1'b0; cand_valid = 1'b0; cand_x = '0; cand_y = '0;
    ver_done = 1'b0; ver_class = 1'b0; res_ready = 1'b0;
    test_reset();
    test_face();
    test_oob();
    test_timeout();
    test_done_at_timeout();
    test_back_to_back();
    test_reset_midstream();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
